// File: rtl/collision_detector.sv
// Per-frame bird/pipe overlap counter with a grace/armed/hit FSM for the game controller.
// Define COLLISION_FLOOR_EN to enable floor-contact detection (FLOOR_Y).
module collision_detector #(
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int HIT_THRESHOLD = 4,
    parameter int GRACE_FRAMES  = 2
`ifdef COLLISION_FLOOR_EN
    ,
    parameter int FLOOR_Y       = 470
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bird_pixel,
    input  logic        pipe_pixel,
    output logic        collision,
    output logic        game_over,
    output logic [11:0] overlap_count,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, GRACE, ARMED, HIT} state_t;

    localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    state_t        state;
    logic [GW-1:0] grace_cnt;
    logic [11:0]   frame_cnt;
    logic [9:0]    prev_h;
    logic [9:0]    prev_v;
    logic          floor_flag;

    logic new_pixel;
    logic frame_start;
    logic visible;
    logic overlap_px;
    logic restart;
    logic eval;
    logic hit_now;

    // The scan may dwell on a coordinate; only its first cycle counts.
    assign new_pixel   = {hCount, vCount} != {prev_h, prev_v};
    assign frame_start = new_pixel && hCount == 10'd0 && vCount == 10'd0;
    assign visible     = hCount < 10'(H_VISIBLE) && vCount < 10'(V_VISIBLE);
    assign overlap_px  = new_pixel && enable && visible && bird_pixel && pipe_pixel;
    assign restart     = clear && state != IDLE;
    assign eval        = frame_start && enable && !restart;
    assign hit_now     = frame_cnt >= 12'(HIT_THRESHOLD) || floor_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_h <= 10'h3FF;
            prev_v <= 10'h3FF;
        end else begin
            prev_h <= hCount;
            prev_v <= vCount;
        end
    end

    // Pixel (0,0) belongs to the frame that starts on it.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            frame_cnt <= 12'd0;
        end else if (eval) begin
            frame_cnt <= overlap_px ? 12'd1 : 12'd0;
        end else if (overlap_px && frame_cnt != 12'hFFF) begin
            frame_cnt <= frame_cnt + 12'd1;
        end
    end

`ifdef COLLISION_FLOOR_EN
    logic floor_px;

    assign floor_px = new_pixel && enable && bird_pixel && vCount >= 10'(FLOOR_Y);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            floor_flag <= 1'b0;
        end else if (eval) begin
            floor_flag <= floor_px;
        end else if (floor_px) begin
            floor_flag <= 1'b1;
        end
    end
`else
    assign floor_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grace_cnt     <= '0;
            collision     <= 1'b0;
            game_over     <= 1'b0;
            overlap_count <= 12'd0;
            frame_done    <= 1'b0;
        end else begin
            collision  <= 1'b0;
            frame_done <= 1'b0;
            if (restart) begin
                state     <= GRACE;
                grace_cnt <= GW'(GRACE_FRAMES);
                game_over <= 1'b0;
            end else if (enable) begin
                if (eval) begin
                    overlap_count <= frame_cnt;
                    frame_done    <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        state     <= GRACE;
                        grace_cnt <= GW'(GRACE_FRAMES);
                    end
                    GRACE: begin
                        if (eval) begin
                            if (grace_cnt == '0) begin
                                state <= ARMED;
                            end else begin
                                grace_cnt <= grace_cnt - 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (eval && hit_now) begin
                            state     <= HIT;
                            collision <= 1'b1;
                            game_over <= 1'b1;
                        end
                    end
                    HIT: begin
                        game_over <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
